// File: rtl/mag_packet_serializer_pkg.sv
// Shared definitions for the magnetometer packet serializer: packet geometry,
// fixed byte order and FSM state encoding.
// Optional feature macro: MAG_SER_CHECKSUM_EN (adds the CSUM state / 11th byte).
package mag_pkg;

  localparam int PKT_W     = 80;
  localparam logic [7:0] MARKER_M = 8'h4D;
  localparam int PKT_BYTES = 10;

  // LSB position of each transmitted byte, in send order
  localparam int B0_LSB = 0;   // marker
  localparam int B1_LSB = 24;  // timestamp, MSB first
  localparam int B2_LSB = 16;
  localparam int B3_LSB = 8;
  localparam int B4_LSB = 72;  // payload, MSB first
  localparam int B5_LSB = 64;
  localparam int B6_LSB = 56;
  localparam int B7_LSB = 48;
  localparam int B8_LSB = 40;
  localparam int B9_LSB = 32;

  typedef enum logic [1:0] {
    IDLE,
    SEND
`ifdef MAG_SER_CHECKSUM_EN
    , CSUM
`endif
  } state_t;

  // Byte i of the outgoing stream for packet p
  function automatic logic [7:0] pkt_byte(input logic [PKT_W-1:0] p, input logic [3:0] i);
    case (i)
      4'd0:    pkt_byte = p[B0_LSB +: 8];
      4'd1:    pkt_byte = p[B1_LSB +: 8];
      4'd2:    pkt_byte = p[B2_LSB +: 8];
      4'd3:    pkt_byte = p[B3_LSB +: 8];
      4'd4:    pkt_byte = p[B4_LSB +: 8];
      4'd5:    pkt_byte = p[B5_LSB +: 8];
      4'd6:    pkt_byte = p[B6_LSB +: 8];
      4'd7:    pkt_byte = p[B7_LSB +: 8];
      4'd8:    pkt_byte = p[B8_LSB +: 8];
      4'd9:    pkt_byte = p[B9_LSB +: 8];
      default: pkt_byte = 8'h00;
    endcase
  endfunction

  // XOR of all packet bytes (order-independent)
  function automatic logic [7:0] pkt_csum(input logic [PKT_W-1:0] p);
    logic [7:0] x;
    x = 8'h00;
    for (int k = 0; k < PKT_BYTES; k++) x ^= pkt_byte(p, 4'(k));
    return x;
  endfunction

endpackage

// File: rtl/mag_packet_serializer_if.sv
// Byte-stream valid/ready channel from the serializer to the writer.
interface mag_packet_serializer_if;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       byte_ready;

  modport master (output byte_out, output byte_valid, input byte_ready);
  modport slave  (input byte_out, input byte_valid, output byte_ready);
endinterface

// File: rtl/mag_pkt_fifo.sv
// DEPTH x PKT_W packet FIFO. Push when full is dropped and counted
// (saturating), with fullness judged before any same-cycle pop.
module mag_pkt_fifo
  import mag_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [PKT_W-1:0]         din,
  input  logic                     pop,
  output logic [PKT_W-1:0]         dout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic [7:0]               drop_count
);
  localparam int AW = $clog2(DEPTH);

  logic [PKT_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic             full, push_ok, pop_ok;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = mem[rptr];

  // storage: contents need no reset, pointers define validity
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= din;
  end

  // pointers, occupancy and drop counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr       <= '0;
      rptr       <= '0;
      level      <= '0;
      drop_count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (push && full && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
    end
  end
endmodule

// File: rtl/mag_packet_serializer.sv
// Magnetometer packet serializer: buffers 80-bit packets and streams each as
// a fixed-order byte sequence over valid/ready.
// Optional feature macro: MAG_SER_CHECKSUM_EN appends an XOR checksum byte.
module mag_packet_serializer
  import mag_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [PKT_W-1:0]            pkt_in,
  input  logic                        pkt_valid,
  mag_packet_serializer_if.master     byte_if,
  output logic [$clog2(DEPTH):0]      fifo_level,
  output logic [7:0]                  drop_count,
  output logic                        busy
);
  localparam logic [3:0] LAST_IDX = 4'(PKT_BYTES - 1);

  state_t           state, nstate;
  logic [PKT_W-1:0] hold, head;
  logic [3:0]       idx;
  logic             pop, empty, accept;
  logic [7:0]       cur_byte;

  mag_pkt_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (pkt_valid),
    .din        (pkt_in),
    .pop        (pop),
    .dout       (head),
    .empty      (empty),
    .level      (fifo_level),
    .drop_count (drop_count)
  );

  assign accept = byte_if.byte_valid & byte_if.byte_ready;
  assign busy   = (state != IDLE);

`ifdef MAG_SER_CHECKSUM_EN
  assign cur_byte = (state == CSUM) ? pkt_csum(hold) : pkt_byte(hold, idx);
`else
  assign cur_byte = pkt_byte(hold, idx);
`endif

  // output only meaningful while a byte is being offered
  assign byte_if.byte_valid = (state != IDLE);
  assign byte_if.byte_out   = byte_if.byte_valid ? cur_byte : 8'h00;

  // next-state and pop decision
  always_comb begin
    nstate = state;
    pop    = 1'b0;
    case (state)
      IDLE: if (!empty) begin
        pop    = 1'b1;
        nstate = SEND;
      end
      SEND: if (accept && idx == LAST_IDX) begin
`ifdef MAG_SER_CHECKSUM_EN
        nstate = CSUM;
`else
        nstate = IDLE;
`endif
      end
`ifdef MAG_SER_CHECKSUM_EN
      CSUM: if (accept) nstate = IDLE;
`endif
      default: nstate = IDLE;
    endcase
  end

  // state, holding register and byte index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      hold  <= '0;
      idx   <= '0;
    end else begin
      state <= nstate;
      if (pop) begin
        hold <= head;
        idx  <= '0;
      end else if (state == SEND && accept && idx != LAST_IDX) begin
        idx <= idx + 4'd1;
      end
    end
  end
endmodule

// File: tb/tb_mag_packet_serializer.sv
// Bench for mag_packet_serializer: directed scenarios plus random traffic,
// every cycle compared against a queue-based packet/byte-stream model.
module tb_mag_packet_serializer;
  localparam int DEPTH = 4;
`ifdef MAG_SER_CHECKSUM_EN
  localparam int BPP = 11;
`else
  localparam int BPP = 10;
`endif

  typedef logic [7:0] bytes_t [11];

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [79:0] pkt_in = '0;
  logic        pkt_valid = 1'b0;
  logic [2:0]  fifo_level;
  logic [7:0]  drop_count;
  logic        busy;

  mag_packet_serializer_if byte_if();

  mag_packet_serializer #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .pkt_in     (pkt_in),
    .pkt_valid  (pkt_valid),
    .byte_if    (byte_if.master),
    .fifo_level (fifo_level),
    .drop_count (drop_count),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // reference model: packet queue, bytes still to send of the current packet
  logic [79:0] mq[$];
  logic [7:0]  oq[$];
  int          mdrop = 0;
  logic [7:0]  dlog[$];

  // byte stream of a packet: marker, timestamp MSB-first, payload MSB-first
  function automatic bytes_t pkt_bytes(input logic [79:0] p);
    bytes_t b;
    logic [7:0] x;
    b[0] = p[7:0];
    for (int k = 0; k < 3; k++) b[1+k] = p[8+8*(2-k) +: 8];
    for (int k = 0; k < 6; k++) b[4+k] = p[32+8*(5-k) +: 8];
    x = 8'h00;
    for (int k = 0; k < 10; k++) x ^= b[k];
    b[10] = x;
    return b;
  endfunction

  function automatic logic [79:0] mk(input int i);
    return {48'(i) * 48'h0001_0203_0405, 24'(i * 3 + 1), 8'h4D};
  endfunction

  // one clock cycle: drive, sample accepted byte, advance model, compare
  task automatic step(input logic v, input logic [79:0] p, input logic rdy);
    bit sending, do_pop, full;
    bytes_t b;
    pkt_valid = v;
    pkt_in = p;
    byte_if.byte_ready = rdy;
    if (byte_if.byte_valid && rdy) dlog.push_back(byte_if.byte_out);
    @(posedge clk);
    sending = (oq.size() > 0);
    do_pop  = !sending && (mq.size() > 0);
    full    = (mq.size() == DEPTH);
    if (sending && rdy) void'(oq.pop_front());
    if (do_pop) begin
      b = pkt_bytes(mq.pop_front());
      for (int k = 0; k < BPP; k++) oq.push_back(b[k]);
    end
    if (v) begin
      if (full) begin
        if (mdrop < 255) mdrop++;
      end else mq.push_back(p);
    end
    #1;
    chk("byte_valid", byte_if.byte_valid, oq.size() > 0);
    if (oq.size() > 0) chk("byte_out", byte_if.byte_out, oq[0]);
    chk("fifo_level", fifo_level, mq.size());
    chk("drop_count", drop_count, mdrop);
    chk("busy", busy, oq.size() > 0);
  endtask

  // asynchronous reset applied mid-cycle; returns at posedge+1
  task automatic do_reset();
    rst = 1'b1;
    pkt_valid = 1'b0;
    #1;
    chk("rst_valid", byte_if.byte_valid, 0);
    chk("rst_byte", byte_if.byte_out, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_busy", busy, 0);
    mq.delete();
    oq.delete();
    mdrop = 0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  logic [7:0]  exp1 [10] = '{8'h4D, 8'hAB, 8'hCD, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
  logic [79:0] p0 = {48'h010203040506, 24'hABCDEF, 8'h4D};
  logic [1:0]  bp_pat = 2'b00;

  initial begin
    bytes_t eb;
    logic [79:0] rp;
    byte_if.byte_ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // single packet, latency and byte order
    dlog.delete();
    step(1'b1, p0, 1'b1);
    step(1'b0, '0, 1'b1);
    chk("lat_valid", byte_if.byte_valid, 1);
    chk("lat_byte0", byte_if.byte_out, 8'h4D);
    repeat (12) step(1'b0, '0, 1'b1);
    chk("single_count", dlog.size(), BPP);
    for (int k = 0; k < 10 && k < dlog.size(); k++) chk($sformatf("single_b%0d", k), dlog[k], exp1[k]);
`ifdef MAG_SER_CHECKSUM_EN
    if (dlog.size() > 10) chk("csum_byte", dlog[10], 8'hC3);
`endif
    chk("single_busy_end", busy, 0);

    // backpressure with ready pattern 1,0,0,1
    dlog.delete();
    step(1'b1, p0, 1'b1);
    for (int i = 0; i < 48; i++) begin
      bp_pat = 2'(i % 4);
      step(1'b0, '0, (bp_pat == 2'd0) || (bp_pat == 2'd3));
    end
    chk("bp_count", dlog.size(), BPP);
    for (int k = 0; k < 10 && k < dlog.size(); k++) chk($sformatf("bp_b%0d", k), dlog[k], exp1[k]);

    // overflow, then full with a push coinciding with the idle pop
    do_reset();
    dlog.delete();
    for (int i = 1; i <= 6; i++) step(1'b1, mk(i), 1'b0);
    chk("ovf_level", fifo_level, 4);
    chk("ovf_drop", drop_count, 1);
    chk("ovf_head", byte_if.byte_out, 8'h4D);
    repeat (10) step(1'b0, '0, 1'b1);
    step(1'b1, mk(7), 1'b1);
    chk("fullpop_level", fifo_level, 3);
    chk("fullpop_drop", drop_count, 2);
    repeat (70) step(1'b0, '0, 1'b1);
    chk("ovf_out_count", dlog.size(), 5 * BPP);
    for (int i = 1; i <= 5; i++) begin
      eb = pkt_bytes(mk(i));
      for (int k = 0; k < BPP; k++)
        if ((i-1)*BPP + k < dlog.size())
          chk($sformatf("ovf_p%0d_b%0d", i, k), dlog[(i-1)*BPP + k], eb[k]);
    end

    // drop counter saturation
    do_reset();
    repeat (262) step(1'b1, {$urandom, $urandom, 16'(($urandom))}, 1'b0);
    chk("drop_sat", drop_count, 8'hFF);

    // reset in the middle of a packet
    do_reset();
    dlog.delete();
    step(1'b1, p0, 1'b1);
    step(1'b1, mk(9), 1'b1);
    repeat (4) step(1'b0, '0, 1'b1);
    chk("mid_sent", dlog.size(), 4);
    do_reset();
    dlog.delete();
    repeat (20) step(1'b0, '0, 1'b1);
    chk("mid_nobytes", dlog.size(), 0);
    step(1'b1, p0, 1'b1);
    step(1'b0, '0, 1'b1);
    chk("mid_restart_valid", byte_if.byte_valid, 1);
    chk("mid_restart_b0", byte_if.byte_out, 8'h4D);
    repeat (12) step(1'b0, '0, 1'b1);

    // random traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rp = {$urandom, $urandom, 16'($urandom)};
      if ($urandom_range(0, 7) != 0) rp[7:0] = 8'h4D;
      step($urandom_range(0, 3) == 0, rp, $urandom_range(0, 9) < 7);
    end
    repeat (80) step(1'b0, '0, 1'b1);
    chk("rand_drained", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mag_packet_serializer.md
Name: mag_packet_serializer

Overview:
Downstream of the magnetometer I2C interface. Captures each 80-bit sample packet ({payload[47:0], timestamp[23:0], marker 8'h4D}) on a valid strobe and buffers it in a small packet FIFO. Emits each packet as a fixed-order byte stream over a valid/ready handshake to the memory/telemetry writer. Counts packets dropped on overflow.

Parameters:
DEPTH, 4, FIFO depth in packets; power of 2, minimum 2.
PKT_W, 80, packet width in bits; fixed at 80.

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  asynchronous, active-high reset.
pkt_in  input  80  packet from the I2C interface: [79:32] payload, [31:8] timestamp, [7:0] marker.
pkt_valid  input  1  one-cycle strobe; pkt_in is valid this cycle.
byte_out  output  8  serialized byte.
byte_valid  output  1  byte_out is valid.
byte_ready  input  1  downstream accepts byte_out when byte_valid is high.
fifo_level  output  $clog2(DEPTH)+1  packets stored, excluding the one being sent.
drop_count  output  8  saturating count of dropped packets.
busy  output  1  high while the state is not IDLE.

Behaviour:
- One clock; reset is asynchronous and active-high. All state updates on the rising edge of clk.
- Reset values: byte_out=0, byte_valid=0, fifo_level=0, drop_count=0, busy=0. FIFO pointers and the byte index are cleared, and the state returns to IDLE.
- Reset mid-packet: the partial packet and all FIFO contents are discarded. No further bytes of that packet are sent.
- Push: pkt_valid=1 and FIFO not full means pkt_in is written and the level increments. Full is judged on the level before any same-cycle pop.
- Push when full: the packet is dropped and drop_count increments, saturating at 8'hFF. This holds even if a pop occurs in the same cycle.
- Simultaneous push and pop when not full: the level is unchanged and both operations take effect.
- FSM states: IDLE, SEND, and CSUM (CSUM only with the optional feature).
  - IDLE: if the FIFO is non-empty, pop the head into an 80-bit holding register, set idx=0, and go to SEND. byte_valid rises in the same edge.
  - SEND: byte_out is byte[idx]. On byte_valid & byte_ready, idx increments. After idx=9 is accepted, go to IDLE (or to CSUM when enabled).
  - IDLE always lasts at least one cycle between packets.
- Byte order (fixed):
  - byte0 = [7:0] (marker).
  - byte1..3 = [31:24], [23:16], [15:8] (timestamp, MSB first).
  - byte4..9 = [79:72], [71:64], [63:56], [55:48], [47:40], [39:32] (payload, MSB first).
- Handshake rules:
  - Once byte_valid is asserted, byte_out holds stable until it is accepted.
  - byte_valid never drops without an accept, except on reset.
- Latency: pkt_valid in cycle N into an empty, idle block gives byte_valid=1 with byte0 in cycle N+2.
- Throughput: 10 cycles per packet with byte_ready held at 1, plus 1 IDLE cycle.
- No content check on the marker; the packet is forwarded as received.

Optional Feature:
MAG_SER_CHECKSUM_EN
- Defined: after byte9 is accepted, enter CSUM and emit an 11th byte equal to the XOR of byte0..byte9. It uses the same handshake, then goes to IDLE.
- Undefined: no CSUM state and exactly 10 bytes per packet.

Decomposition:
- Package mag_pkg holds:
  - PKT_W=80 and MARKER_M=8'h4D.
  - PKT_BYTES=10.
  - Byte-slice localparams for the fixed order.
  - The state typedef/encoding (IDLE, SEND, CSUM).
- Sub-module mag_pkt_fifo holds the synchronous DEPTH x 80 FIFO with push, pop, full, empty, level and the drop rule. The serializer FSM stays in the top block.

Test Plan:
- Single packet: pkt_in = {48'h010203040506, 24'hABCDEF, 8'h4D}, byte_ready=1.
  - Expect bytes 4D AB CD EF 01 02 03 04 05 06 in consecutive cycles.
  - First byte appears 2 cycles after pkt_valid; busy returns low after the last byte.
- Backpressure: same packet, byte_ready toggles 1,0,0,1 repeating. Expect the same 10 bytes, and byte_out stable and byte_valid held during every ready=0 cycle.
- Overflow: DEPTH=4, byte_ready=0, push 6 packets.
  - Expect one packet in the holding register, fifo_level=4, drop_count=1.
  - Releasing ready gives 5 packets out in push order.
- Full plus simultaneous push/pop: FIFO full, and a push coincides with the IDLE pop. Expect the push dropped, drop_count incremented, and fifo_level=3.
- Reset mid-packet: assert rst after byte3 is accepted, then release.
  - Expect byte_valid=0 immediately, fifo_level=0, and no further bytes.
  - A new packet is then sent from byte0.
- MAG_SER_CHECKSUM_EN defined, single-packet stimulus: expect an 11th byte C3.
